// File: rtl/bram_arbiter_if.sv
// BRAM_IF transaction port shared by the arbiter (master) and the BRAM
// interface block (slave): start lines, latched addresses/data, read data
// and the completion level.
interface bram_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              axi_start_read;
  logic              axi_start_write;
  logic              nn_start_read;
  logic [31:0]       axi_addr;
  logic [DATA_W-1:0] axi_wdata;
  logic [31:0]       nn_addr;
  logic [DATA_W-1:0] axi_rdata;
  logic [DATA_W-1:0] nn_rdata;
  logic              complete;

  modport master (
    output axi_start_read, axi_start_write, nn_start_read,
    output axi_addr, axi_wdata, nn_addr,
    input  axi_rdata, nn_rdata, complete
  );

  modport slave (
    input  axi_start_read, axi_start_write, nn_start_read,
    input  axi_addr, axi_wdata, nn_addr,
    output axi_rdata, nn_rdata, complete
  );
endinterface

// File: rtl/bram_arbiter.sv
// Shares the single BRAM_IF transaction port between the AXI register side
// (single read/write) and the NN engine (multi-beat read bursts). One start
// line is driven at a time, held until complete, followed by the release
// handshake and a one-cycle done/valid pulse back to the requester.
module bram_arbiter #(
  parameter int DATA_W        = 16,
  parameter int LEN_W         = 8,
  parameter int ADDR_INC      = 4,
  parameter int MAX_NN_STREAK = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              axi_req_rd,
  input  logic              axi_req_wr,
  input  logic [31:0]       axi_addr,
  input  logic [DATA_W-1:0] axi_wdata,
  output logic [DATA_W-1:0] axi_rdata,
  output logic              axi_done,
  input  logic              nn_burst_start,
  input  logic [31:0]       nn_base_addr,
  input  logic [LEN_W-1:0]  nn_burst_len,
  output logic              nn_busy,
  output logic [DATA_W-1:0] nn_rdata,
  output logic              nn_rdata_valid,
  output logic              nn_burst_done,
  bram_arbiter_if.master    bif,
  output logic              bif_timeout
);

  localparam int STREAK_W = $clog2(MAX_NN_STREAK + 1);
  localparam int WD_W     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, GRANT_AXI, GRANT_NN, RELEASE} state_t;

  state_t              state, state_d;
  logic                side_nn;     // owner of the transaction being released
  logic                is_wr;
  logic [STREAK_W-1:0] nn_streak;
  logic [31:0]         nn_base;
  logic [LEN_W-1:0]    nn_len;
  logic [LEN_W-1:0]    nn_beat;
  logic [WD_W-1:0]     wd_cnt;

  logic axi_pend, nn_pend;
  logic pick_axi, pick_nn, grant_ok, grant_abort, rel_done;

  // Next-state decode, arbitration and start-line outputs
  always_comb begin
    state_d             = state;
    axi_pend            = (axi_req_rd | axi_req_wr) & ~axi_done;
    nn_pend             = nn_busy & (nn_beat != nn_len);
    pick_axi            = 1'b0;
    pick_nn             = 1'b0;
    grant_ok            = 1'b0;
    grant_abort         = 1'b0;
    rel_done            = 1'b0;
    bif.axi_start_read  = 1'b0;
    bif.axi_start_write = 1'b0;
    bif.nn_start_read   = 1'b0;
    case (state)
      IDLE: begin
        if (axi_pend && (!nn_pend || nn_streak >= STREAK_W'(MAX_NN_STREAK))) begin
          pick_axi = 1'b1;
          state_d  = GRANT_AXI;
        end else if (nn_pend) begin
          pick_nn = 1'b1;
          state_d = GRANT_NN;
        end
      end
      GRANT_AXI, GRANT_NN: begin
        bif.axi_start_read  = (state == GRANT_AXI) & ~is_wr;
        bif.axi_start_write = (state == GRANT_AXI) & is_wr;
        bif.nn_start_read   = (state == GRANT_NN);
        if (bif.complete) begin
          grant_ok = 1'b1;
          state_d  = RELEASE;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
          grant_abort = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!bif.complete) begin
          rel_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge axi_clk) begin
    if (axi_rst) state <= IDLE;
    else         state <= state_d;
  end

  // Burst bookkeeping, address/data latching, capture and completion pulses
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      side_nn        <= 1'b0;
      is_wr          <= 1'b0;
      nn_streak      <= '0;
      nn_base        <= '0;
      nn_len         <= '0;
      nn_beat        <= '0;
      wd_cnt         <= '0;
      nn_busy        <= 1'b0;
      axi_rdata      <= '0;
      axi_done       <= 1'b0;
      nn_rdata       <= '0;
      nn_rdata_valid <= 1'b0;
      nn_burst_done  <= 1'b0;
      bif_timeout    <= 1'b0;
      bif.axi_addr   <= '0;
      bif.axi_wdata  <= '0;
      bif.nn_addr    <= '0;
    end else begin
      axi_done       <= 1'b0;
      nn_rdata_valid <= 1'b0;
      nn_burst_done  <= 1'b0;

      // busy covers the done cycle, then drops; a zero-length burst never sets it
      if (nn_burst_done) nn_busy <= 1'b0;
      if (nn_burst_start && !nn_busy) begin
        nn_base <= nn_base_addr;
        nn_len  <= nn_burst_len;
        nn_beat <= '0;
        if (nn_burst_len == '0) nn_burst_done <= 1'b1;
        else                    nn_busy       <= 1'b1;
      end

      if (state == GRANT_AXI || state == GRANT_NN) wd_cnt <= wd_cnt + 1'b1;

      if (pick_axi) begin
        bif.axi_addr  <= axi_addr;
        bif.axi_wdata <= axi_wdata;
        is_wr         <= ~axi_req_rd;
        side_nn       <= 1'b0;
        nn_streak     <= '0;
        wd_cnt        <= '0;
      end

      if (pick_nn) begin
        bif.nn_addr <= nn_base + ({{(32-LEN_W){1'b0}}, nn_beat} * 32'(ADDR_INC));
        side_nn     <= 1'b1;
        wd_cnt      <= '0;
        if (nn_streak < STREAK_W'(MAX_NN_STREAK)) nn_streak <= nn_streak + 1'b1;
      end

      if (grant_ok) begin
        if (state == GRANT_NN) nn_rdata  <= bif.nn_rdata;
        else                   axi_rdata <= bif.axi_rdata;
      end

      // an aborted transaction still completes, with zeroed data
      if (grant_abort) begin
        bif_timeout <= 1'b1;
        if (state == GRANT_NN) nn_rdata  <= '0;
        else                   axi_rdata <= '0;
      end

      if (rel_done) begin
        if (side_nn) begin
          nn_rdata_valid <= 1'b1;
          nn_beat        <= nn_beat + 1'b1;
          if (nn_beat + 1'b1 == nn_len) nn_burst_done <= 1'b1;
        end else begin
          axi_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed testbench for bram_arbiter with a behavioural BRAM_IF responder.
module tb_bram_arbiter;

  localparam int LAT = 2;

  logic        axi_clk = 1'b0;
  logic        axi_rst;
  logic        axi_req_rd, axi_req_wr;
  logic [31:0] axi_addr;
  logic [15:0] axi_wdata;
  logic [15:0] axi_rdata;
  logic        axi_done;
  logic        nn_burst_start;
  logic [31:0] nn_base_addr;
  logic [7:0]  nn_burst_len;
  logic        nn_busy;
  logic [15:0] nn_rdata;
  logic        nn_rdata_valid;
  logic        nn_burst_done;
  logic        bif_timeout;

  bram_arbiter_if #(.DATA_W(16)) bif ();

  bram_arbiter dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .axi_req_rd(axi_req_rd), .axi_req_wr(axi_req_wr),
    .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_rdata(axi_rdata), .axi_done(axi_done),
    .nn_burst_start(nn_burst_start), .nn_base_addr(nn_base_addr),
    .nn_burst_len(nn_burst_len), .nn_busy(nn_busy),
    .nn_rdata(nn_rdata), .nn_rdata_valid(nn_rdata_valid),
    .nn_burst_done(nn_burst_done), .bif(bif), .bif_timeout(bif_timeout)
  );

  always #5 axi_clk = ~axi_clk;

  logic [119:0] all_outs;
  assign all_outs = {axi_rdata, axi_done, nn_busy, nn_rdata, nn_rdata_valid,
                     nn_burst_done, bif.axi_start_read, bif.axi_start_write,
                     bif.nn_start_read, bif.axi_addr, bif.axi_wdata, bif.nn_addr,
                     bif_timeout};

  int checks = 0;
  int fails  = 0;

  // BRAM_IF model: unwritten words read as addr[15:0] ^ 16'hA5A5
  logic [15:0] mem [logic [31:0]];
  logic        hang = 1'b0;
  int          cnt  = 0;

  function automatic logic [15:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // monitor state
  int          n_axi_done, n_valid, n_bdone, n_multi;
  logic [15:0] nn_data_q [$];
  logic        order_q [$];
  logic [31:0] nn_addr_q [$];

  // responder: raise complete LAT cycles after a start, drop it once start drops
  initial begin
    bif.complete  = 1'b0;
    bif.axi_rdata = '0;
    bif.nn_rdata  = '0;
    forever begin
      @(negedge axi_clk);
      if (axi_rst) begin
        bif.complete = 1'b0;
        cnt = 0;
      end else if (bif.axi_start_read | bif.axi_start_write | bif.nn_start_read) begin
        if (!bif.complete) begin
          if (cnt == 0 && bif.nn_start_read) nn_addr_q.push_back(bif.nn_addr);
          cnt++;
          if (cnt >= LAT && !hang) begin
            bif.complete = 1'b1;
            if (bif.axi_start_write) begin
              mem[bif.axi_addr] = bif.axi_wdata;
              bif.axi_rdata = bif.axi_wdata;
            end else if (bif.axi_start_read) begin
              bif.axi_rdata = memrd(bif.axi_addr);
            end else begin
              bif.nn_rdata = memrd(bif.nn_addr);
            end
          end
        end
      end else begin
        bif.complete = 1'b0;
        cnt = 0;
      end
    end
  end

  // pulse / ordering monitor
  always @(negedge axi_clk) begin
    if (axi_done) begin
      n_axi_done++;
      order_q.push_back(1'b0);
    end
    if (nn_rdata_valid) begin
      n_valid++;
      nn_data_q.push_back(nn_rdata);
      order_q.push_back(1'b1);
    end
    if (nn_burst_done) n_bdone++;
    if ($countones({bif.axi_start_read, bif.axi_start_write, bif.nn_start_read}) > 1) n_multi++;
  end

  task automatic step;
    @(negedge axi_clk);
    #1;
  endtask

  task automatic clear_mon;
    n_axi_done = 0; n_valid = 0; n_bdone = 0; n_multi = 0;
    nn_data_q.delete(); order_q.delete(); nn_addr_q.delete();
  endtask

  task automatic do_reset;
    axi_rst = 1'b1; axi_req_rd = 1'b0; axi_req_wr = 1'b0;
    axi_addr = '0; axi_wdata = '0; nn_burst_start = 1'b0;
    nn_base_addr = '0; nn_burst_len = '0; hang = 1'b0;
    step(); step();
    axi_rst = 1'b0;
    clear_mon();
  endtask

  task automatic axi_xact(input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                          output int done_cyc, output int rd_cyc, output int wr_cyc,
                          output int nn_cyc, output int addr_bad);
    done_cyc = -1; rd_cyc = 0; wr_cyc = 0; nn_cyc = 0; addr_bad = 0;
    axi_addr = addr; axi_wdata = wd; axi_req_rd = !wr; axi_req_wr = wr;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (bif.axi_start_read)  rd_cyc++;
      if (bif.axi_start_write) wr_cyc++;
      if (bif.nn_start_read)   nn_cyc++;
      if ((bif.axi_start_read | bif.axi_start_write) && bif.axi_addr !== addr) addr_bad++;
      if (axi_done) begin
        done_cyc = i;
        break;
      end
    end
    axi_req_rd = 1'b0; axi_req_wr = 1'b0;
  endtask

  task automatic test_reset;
    axi_rst = 1'b1; axi_req_rd = 1'b1; axi_req_wr = 1'b0; axi_addr = 32'h44;
    axi_wdata = 16'h1234; nn_burst_start = 1'b1; nn_base_addr = 32'h80; nn_burst_len = 8'd2;
    step(); step();
    checks++; if (all_outs !== '0) begin fails++; $display("FAIL reset_outputs: got %0h, expected 0", all_outs); end
    do_reset();
    step();
    checks++; if (nn_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b, expected 0", nn_busy); end
  endtask

  task automatic test_axi_read;
    int dc, rc, wc, nc, ab;
    do_reset();
    axi_xact(1'b0, 32'h10, 16'h0, dc, rc, wc, nc, ab);
    checks++; if (dc !== 4) begin fails++; $display("FAIL rd_done_cycle: got %0d, expected 4", dc); end
    checks++; if (rc !== 2) begin fails++; $display("FAIL rd_start_cycles: got %0d, expected 2", rc); end
    checks++; if (wc + nc !== 0) begin fails++; $display("FAIL rd_other_starts: got %0d, expected 0", wc + nc); end
    checks++; if (ab !== 0) begin fails++; $display("FAIL rd_addr: got %0d bad cycles, expected 0", ab); end
    checks++; if (axi_rdata !== 16'hA5B5) begin fails++; $display("FAIL rd_data: got %0h, expected a5b5", axi_rdata); end
    repeat (5) step();
    checks++; if (n_axi_done !== 1) begin fails++; $display("FAIL rd_done_count: got %0d, expected 1", n_axi_done); end
    checks++; if (axi_rdata !== 16'hA5B5) begin fails++; $display("FAIL rd_data_hold: got %0h, expected a5b5", axi_rdata); end
  endtask

  task automatic test_axi_write;
    int dc, rc, wc, nc, ab;
    do_reset();
    axi_xact(1'b1, 32'h20, 16'hBEEF, dc, rc, wc, nc, ab);
    checks++; if (dc !== 4) begin fails++; $display("FAIL wr_done_cycle: got %0d, expected 4", dc); end
    checks++; if (wc !== 2) begin fails++; $display("FAIL wr_start_cycles: got %0d, expected 2", wc); end
    checks++; if (rc + nc !== 0) begin fails++; $display("FAIL wr_other_starts: got %0d, expected 0", rc + nc); end
    checks++; if (axi_rdata !== 16'hBEEF) begin fails++; $display("FAIL wr_readback: got %0h, expected beef", axi_rdata); end
    checks++; if (bif.axi_wdata !== 16'hBEEF) begin fails++; $display("FAIL wr_wdata_latch: got %0h, expected beef", bif.axi_wdata); end
    step();
    axi_xact(1'b0, 32'h20, 16'h0, dc, rc, wc, nc, ab);
    checks++; if (axi_rdata !== 16'hBEEF) begin fails++; $display("FAIL wr_then_rd: got %0h, expected beef", axi_rdata); end
    checks++; if (n_axi_done !== 2) begin fails++; $display("FAIL wr_done_count: got %0d, expected 2", n_axi_done); end
  endtask

  task automatic test_zero_len;
    do_reset();
    nn_base_addr = 32'h0; nn_burst_len = 8'd0; nn_burst_start = 1'b1;
    step();
    nn_burst_start = 1'b0;
    checks++; if ({nn_burst_done, nn_busy} !== 2'b10) begin fails++; $display("FAIL zlen_done: got done/busy %b, expected 10", {nn_burst_done, nn_busy}); end
    step(); step();
    checks++; if ({nn_burst_done, nn_busy, bif.nn_start_read} !== 3'b000) begin fails++; $display("FAIL zlen_after: got %b, expected 000", {nn_burst_done, nn_busy, bif.nn_start_read}); end
    checks++; if (n_valid + nn_addr_q.size() !== 0) begin fails++; $display("FAIL zlen_access: got %0d, expected 0", n_valid + nn_addr_q.size()); end
  endtask

  task automatic test_burst_wrap;
    logic [31:0] exp_a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [15:0] exp_d [4] = '{16'h5A5D, 16'h5A59, 16'hA5A5, 16'hA5A1};
    logic done_seen;
    do_reset();
    nn_base_addr = 32'hFFFF_FFF8; nn_burst_len = 8'd4; nn_burst_start = 1'b1;
    step();
    nn_burst_start = 1'b0;
    checks++; if (nn_busy !== 1'b1) begin fails++; $display("FAIL wrap_busy_start: got %0b, expected 1", nn_busy); end
    done_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (nn_burst_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    checks++; if ({done_seen, nn_rdata_valid, nn_busy} !== 3'b111) begin fails++; $display("FAIL wrap_done_cycle: got done/valid/busy %b, expected 111", {done_seen, nn_rdata_valid, nn_busy}); end
    step();
    checks++; if (nn_busy !== 1'b0) begin fails++; $display("FAIL wrap_busy_drop: got %0b, expected 0", nn_busy); end
    checks++; if (n_valid !== 4) begin fails++; $display("FAIL wrap_valid_count: got %0d, expected 4", n_valid); end
    checks++; if (nn_addr_q.size() !== 4) begin fails++; $display("FAIL wrap_addr_count: got %0d, expected 4", nn_addr_q.size()); end
    for (int i = 0; i < 4 && i < nn_addr_q.size() && i < nn_data_q.size(); i++) begin
      checks++; if (nn_addr_q[i] !== exp_a[i]) begin fails++; $display("FAIL wrap_addr%0d: got %0h, expected %0h", i, nn_addr_q[i], exp_a[i]); end
      checks++; if (nn_data_q[i] !== exp_d[i]) begin fails++; $display("FAIL wrap_data%0d: got %0h, expected %0h", i, nn_data_q[i], exp_d[i]); end
    end
    checks++; if (n_multi !== 0) begin fails++; $display("FAIL wrap_onehot: got %0d, expected 0", n_multi); end
  endtask

  task automatic test_priority;
    logic [10:0] got;
    logic        done_seen;
    do_reset();
    nn_base_addr = 32'h100; nn_burst_len = 8'd10; nn_burst_start = 1'b1;
    step();
    nn_burst_start = 1'b0;
    axi_addr = 32'h40; axi_req_rd = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      nn_burst_start = (i == 5);
      if (i == 5) begin
        nn_base_addr = 32'h900; nn_burst_len = 8'd2;
      end
      step();
      if (axi_done) axi_req_rd = 1'b0;
      if (nn_burst_done) begin
        done_seen = 1'b1;
        break;
      end
    end
    nn_burst_start = 1'b0;
    got = '0;
    for (int i = 0; i < order_q.size() && i < 11; i++) got = {got[9:0], order_q[i]};
    checks++; if (done_seen !== 1'b1) begin fails++; $display("FAIL prio_burst_done: got %0b, expected 1", done_seen); end
    checks++; if (order_q.size() !== 11) begin fails++; $display("FAIL prio_event_count: got %0d, expected 11", order_q.size()); end
    checks++; if (got !== 11'b11110111111) begin fails++; $display("FAIL prio_order: got %b, expected 11110111111", got); end
    checks++; if (axi_rdata !== 16'hA5E5) begin fails++; $display("FAIL prio_axi_data: got %0h, expected a5e5", axi_rdata); end
    if (nn_addr_q.size() == 10) begin
      checks++; if (nn_addr_q[9] !== 32'h124) begin fails++; $display("FAIL prio_last_addr: got %0h, expected 124", nn_addr_q[9]); end
    end else begin
      checks++; fails++; $display("FAIL prio_addr_count: got %0d, expected 10", nn_addr_q.size());
    end
    repeat (30) step();
    checks++; if (n_valid !== 10) begin fails++; $display("FAIL prio_valid_count: got %0d, expected 10", n_valid); end
    checks++; if ({n_bdone, n_axi_done} !== {32'd1, 32'd1}) begin fails++; $display("FAIL prio_pulse_counts: got bdone %0d done %0d, expected 1 1", n_bdone, n_axi_done); end
    checks++; if (nn_busy !== 1'b0) begin fails++; $display("FAIL prio_ignored_start: got busy %0b, expected 0", nn_busy); end
  endtask

  task automatic test_timeout;
    int dc, rc, wc, nc, ab;
    do_reset();
    axi_xact(1'b0, 32'h50, 16'h0, dc, rc, wc, nc, ab);
    checks++; if ({bif_timeout, axi_rdata} !== {1'b0, 16'hA5F5}) begin fails++; $display("FAIL to_pre: got flag %0b data %0h, expected 0 a5f5", bif_timeout, axi_rdata); end
    step();
    hang = 1'b1;
    axi_xact(1'b0, 32'h30, 16'h0, dc, rc, wc, nc, ab);
    hang = 1'b0;
    checks++; if (rc !== 64) begin fails++; $display("FAIL to_grant_cycles: got %0d, expected 64", rc); end
    checks++; if (dc !== 66) begin fails++; $display("FAIL to_done_cycle: got %0d, expected 66", dc); end
    checks++; if (axi_rdata !== 16'h0) begin fails++; $display("FAIL to_data: got %0h, expected 0", axi_rdata); end
    checks++; if (bif_timeout !== 1'b1) begin fails++; $display("FAIL to_flag: got %0b, expected 1", bif_timeout); end
    step();
    axi_xact(1'b0, 32'h50, 16'h0, dc, rc, wc, nc, ab);
    checks++; if ({bif_timeout, axi_rdata} !== {1'b1, 16'hA5F5}) begin fails++; $display("FAIL to_sticky: got flag %0b data %0h, expected 1 a5f5", bif_timeout, axi_rdata); end
    do_reset();
    checks++; if (bif_timeout !== 1'b0) begin fails++; $display("FAIL to_reset_clear: got %0b, expected 0", bif_timeout); end
  endtask

  task automatic test_reset_mid_burst;
    logic hit;
    do_reset();
    nn_base_addr = 32'h200; nn_burst_len = 8'd3; nn_burst_start = 1'b1;
    step();
    nn_burst_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_valid == 1 && bif.nn_start_read) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (hit !== 1'b1) begin fails++; $display("FAIL mid_reach_grant: got %0b, expected 1", hit); end
    axi_rst = 1'b1;
    step();
    checks++; if (all_outs !== '0) begin fails++; $display("FAIL mid_outputs: got %0h, expected 0", all_outs); end
    axi_rst = 1'b0;
    repeat (20) step();
    checks++; if ({n_bdone, n_valid} !== {32'd0, 32'd1}) begin fails++; $display("FAIL mid_no_pulse: got bdone %0d valid %0d, expected 0 1", n_bdone, n_valid); end
    nn_base_addr = 32'h300; nn_burst_len = 8'd2; nn_burst_start = 1'b1;
    step();
    nn_burst_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (nn_burst_done) break;
    end
    checks++; if ({n_bdone, n_valid} !== {32'd1, 32'd3}) begin fails++; $display("FAIL mid_new_burst: got bdone %0d valid %0d, expected 1 3", n_bdone, n_valid); end
    checks++; if (nn_rdata !== 16'hA6A1) begin fails++; $display("FAIL mid_new_data: got %0h, expected a6a1", nn_rdata); end
    if (nn_data_q.size() == 3) begin
      checks++; if (nn_data_q[1] !== 16'hA6A5) begin fails++; $display("FAIL mid_first_beat: got %0h, expected a6a5", nn_data_q[1]); end
    end else begin
      checks++; fails++; $display("FAIL mid_beat_count: got %0d, expected 3", nn_data_q.size());
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_axi_read();
    test_axi_write();
    test_zero_len();
    test_burst_wrap();
    test_priority();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Sequences and shares the single BRAM_IF transaction port between two requesters.
  - AXI register-side requester: single read or write.
  - NN engine: multi-beat read bursts.
- Drives exactly one BRAM_IF start line at a time and holds it until bram_complete.
- Runs BRAM_IF's release handshake, then returns data and done pulses to the requester.
- Applies bounded-priority arbitration and a completion watchdog.

Parameters:
- DATA_W, 16, BRAM data width (matches `DATA_BIT_NUM).
- LEN_W, 8, NN burst length counter width.
- ADDR_INC, 4, byte-address increment per NN beat.
- MAX_NN_STREAK, 4, consecutive NN grants allowed while AXI is pending.
- TIMEOUT_CYC, 64, cycles in GRANT without bram_complete before abort.

Ports:
- axi_clk  in  1  single clock
- axi_rst  in  1  reset, synchronous, active-high
- axi_req_rd  in  1  AXI read request, level, held until axi_done
- axi_req_wr  in  1  AXI write request, level, held until axi_done
- axi_addr  in  32  AXI address
- axi_wdata  in  DATA_W  AXI write data
- axi_rdata  out  DATA_W  AXI read / readback data
- axi_done  out  1  one-cycle AXI completion pulse
- nn_burst_start  in  1  pulse, starts NN burst
- nn_base_addr  in  32  burst base address
- nn_burst_len  in  LEN_W  beats in burst
- nn_busy  out  1  burst in progress
- nn_rdata  out  DATA_W  beat data
- nn_rdata_valid  out  1  one-cycle beat-valid pulse
- nn_burst_done  out  1  one-cycle pulse, coincident with last valid
- bif_axi_start_read  out  1  to BRAM_IF axi_start_read
- bif_axi_start_write  out  1  to BRAM_IF axi_start_write
- bif_nn_start_read  out  1  to BRAM_IF nn_start_read
- bif_axi_addr  out  32  to BRAM_IF axi_bram_addr
- bif_axi_wdata  out  DATA_W  to BRAM_IF axi_bram_write_data
- bif_nn_addr  out  32  to BRAM_IF nn_bram_addr
- bif_axi_rdata  in  DATA_W  from BRAM_IF axi_bram_read_data
- bif_nn_rdata  in  DATA_W  from BRAM_IF nn_bram_read_data
- bif_complete  in  1  from BRAM_IF bram_complete
- bif_timeout  out  1  sticky watchdog flag

Behaviour:

Reset:
- Synchronous on the axi_clk posedge while axi_rst=1.
- Every output resets to 0; state goes to IDLE; burst counters and nn_streak clear.
- Reset mid-transaction aborts it silently: no done or valid pulse is issued.

State machine: IDLE, GRANT_AXI, GRANT_NN, RELEASE.

IDLE:
- Requests are evaluated only in IDLE.
- AXI is pending if (axi_req_rd | axi_req_wr) and axi_done=0. The cycle carrying axi_done is a lockout for AXI requests.
- NN is pending if a burst is active with beats remaining.
- Only one side pending: grant it.
- Both pending: grant AXI if nn_streak >= MAX_NN_STREAK, else grant NN.
- nn_streak increments (saturating) on each NN grant and clears on each AXI grant.
- If axi_req_rd=1 and axi_req_wr=1 together, the request is a read.

GRANT_AXI:
- On entry, latch axi_addr and axi_wdata into bif_axi_addr and bif_axi_wdata. These stay stable until the next grant.
- Assert exactly one of bif_axi_start_read or bif_axi_start_write.

GRANT_NN:
- On entry, drive bif_nn_addr = base + beat*ADDR_INC, modulo 2^32 (wraps silently).
- Assert bif_nn_start_read.

Leaving GRANT (either side):
- On bif_complete=1: capture bif_axi_rdata or bif_nn_rdata into the output register, deassert all starts, go to RELEASE.
- For writes, axi_rdata carries the BRAM_IF write-then-readback value.
- A watchdog counts GRANT cycles. When it reaches TIMEOUT_CYC without bif_complete:
  - deassert starts, set bif_timeout (sticky until reset);
  - captured data = 0;
  - go to RELEASE and finish normally (the done/valid pulse is still issued).

RELEASE:
- Wait for bif_complete=0, then go to IDLE.
- Pulse axi_done, or nn_rdata_valid plus nn_burst_done on the last beat, for one cycle on the posedge that enters IDLE.
- Output data is valid in that cycle and holds afterwards.

Bursts:
- nn_burst_start is accepted only when nn_busy=0; otherwise it is ignored.
- On accept, latch base and length. nn_busy=1 from the next cycle through the nn_burst_done cycle.
- nn_burst_len=0: nn_burst_done pulses the next cycle, no BRAM access, and nn_busy stays 0.

Latency:
- Minimum one posedge from IDLE to start assertion.
- Total time is BRAM_IF completion time plus release time plus 1 cycle.

Test Plan:
1. After reset, axi_req_rd=1, axi_addr=0x10 -> bif_axi_start_read=1 with bif_axi_addr=0x10 until bif_complete; then one axi_done pulse with axi_rdata = the BRAM model's value at 0x10; all other starts stay 0.
2. AXI write addr=0x20, wdata=0xBEEF -> bif_axi_start_write held, axi_done pulses once, axi_rdata=0xBEEF; a following read of 0x20 returns 0xBEEF.
3. Burst base=0xFFFFFFF8, len=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; four valid pulses; nn_burst_done with the 4th; nn_busy drops the next cycle.
4. Burst len=10 with axi_req_rd held from the start -> AXI granted after exactly 4 NN beats; NN resumes afterward; 10 valid pulses total; a second nn_burst_start while busy is ignored.
5. BRAM model never asserts complete -> starts drop after 64 GRANT cycles; bif_timeout=1 (sticky); axi_done pulses with axi_rdata=0.
6. axi_rst asserted during GRANT_NN of a 3-beat burst -> next cycle all outputs 0, no nn_burst_done; a new burst after reset completes normally.
